// File: rtl/fabric_frame_loader_if.sv
// Configuration word stream between the bitstream source and the frame loader.
//   WordData  : 32-bit configuration word (source -> loader)
//   WordValid : WordData valid (source -> loader)
//   WordReady : loader can accept (loader -> source)
// A word transfers on the rising edge where WordValid and WordReady are both high.
interface fabric_frame_loader_if #(
    parameter int unsigned DataWidth = 32
);
    logic [DataWidth-1:0] WordData;
    logic                 WordValid;
    logic                 WordReady;

    modport master (output WordData, output WordValid, input WordReady);
    modport slave  (input WordData, input WordValid, output WordReady);
endinterface

// File: rtl/fabric_frame_loader.sv
// Bitstream front-end: waits for the sync word, parses frame headers, pushes each
// frame's data words onto FrameData with a one-hot RowSelect, then fires one
// FrameStrobe/ColSelect pulse to commit the frame.
//   CLK, resetn : clock, asynchronous active-low reset
//   word        : configuration word stream (slave side)
//   FrameData   : registered row data
//   RowSelect   : one-hot row latch enable, one cycle per data word
//   FrameStrobe : one-hot frame strobe, one cycle per frame
//   ColSelect   : one-hot column select, coincident with FrameStrobe
//   Busy        : high in every state except IDLE (state decode)
//   Error       : sticky header error, cleared by the next sync word
//   FrameCount  : frames strobed since the last sync
module fabric_frame_loader #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 16,
    parameter int unsigned NumCols         = 16,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter logic [31:0] DesyncWord      = 32'hFFFF_FFFF
) (
    input  logic                       CLK,
    input  logic                       resetn,
    fabric_frame_loader_if.slave       word,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [NumRows-1:0]         RowSelect,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NumCols-1:0]         ColSelect,
    output logic                       Busy,
    output logic                       Error,
    output logic [15:0]                FrameCount
);

    localparam int unsigned COL_W   = $clog2(NumCols);
    localparam int unsigned FRAME_W = $clog2(MaxFramesPerCol);
    localparam int unsigned ROW_W   = $clog2(NumRows);
    localparam int unsigned CNT_W   = $clog2(NumRows + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]           col_q, col_d;
    logic [FRAME_W-1:0]         frame_q, frame_d;
    logic [CNT_W-1:0]           rows_q, rows_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [FrameBitsPerRow-1:0] frame_data_d;
    logic [NumRows-1:0]         row_select_d;
    logic [MaxFramesPerCol-1:0] frame_strobe_d;
    logic [NumCols-1:0]         col_select_d;
    logic                       error_d;
    logic [15:0]                frame_count_d;

    // Header field decode
    logic [4:0]  hdr_col;
    logic [4:0]  hdr_frame;
    logic [15:0] hdr_rows;
    logic        hdr_bad_c;
    logic        xfer_c;
    logic        last_row_c;
    logic        unused_hdr_bits;

    assign hdr_col         = word.WordData[31:27];
    assign hdr_frame       = word.WordData[26:22];
    assign hdr_rows        = word.WordData[15:0];
    assign unused_hdr_bits = ^word.WordData[21:16];

    assign hdr_bad_c = (32'(hdr_col) >= NumCols) || (32'(hdr_frame) >= MaxFramesPerCol) ||
                       (hdr_rows == 16'd0) || (32'(hdr_rows) > NumRows);

    // Handshake status decodes the state only
    assign word.WordReady = (state_q != STROBE);
    assign Busy           = (state_q != IDLE);

    assign xfer_c     = word.WordValid && word.WordReady;
    assign last_row_c = ((32'(row_q) + 32'd1) == 32'(rows_q));

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        frame_d        = frame_q;
        rows_d         = rows_q;
        row_d          = row_q;
        frame_data_d   = FrameData;
        row_select_d   = '0;
        frame_strobe_d = '0;
        col_select_d   = '0;
        error_d        = Error;
        frame_count_d  = FrameCount;

        unique case (state_q)
            IDLE: begin
                if (xfer_c && (word.WordData == SyncWord)) begin
                    state_d       = HDR;
                    error_d       = 1'b0;
                    frame_count_d = 16'd0;
                end
            end
            HDR: begin
                if (xfer_c) begin
                    if (word.WordData == DesyncWord) begin
                        state_d = IDLE;
                    end else if (hdr_bad_c) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                        col_d   = COL_W'(hdr_col);
                        frame_d = FRAME_W'(hdr_frame);
                        rows_d  = CNT_W'(hdr_rows);
                        row_d   = '0;
                    end
                end
            end
            DATA: begin
                // Sync/desync values are plain data here
                if (xfer_c) begin
                    frame_data_d = word.WordData;
                    row_select_d = NumRows'(1) << row_q;
                    row_d        = ROW_W'(row_q + ROW_W'(1));
                    if (last_row_c) begin
                        state_d = STROBE;
                    end
                end
            end
            STROBE: begin
                // Row data was latched the cycle before; commit the frame now
                frame_strobe_d = MaxFramesPerCol'(1) << frame_q;
                col_select_d   = NumCols'(1) << col_q;
                frame_count_d  = FrameCount + 16'd1;
                state_d        = HDR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            col_q       <= '0;
            frame_q     <= '0;
            rows_q      <= '0;
            row_q       <= '0;
            FrameData   <= '0;
            RowSelect   <= '0;
            FrameStrobe <= '0;
            ColSelect   <= '0;
            Error       <= 1'b0;
            FrameCount  <= 16'd0;
        end else begin
            col_q       <= col_d;
            frame_q     <= frame_d;
            rows_q      <= rows_d;
            row_q       <= row_d;
            FrameData   <= frame_data_d;
            RowSelect   <= row_select_d;
            FrameStrobe <= frame_strobe_d;
            ColSelect   <= col_select_d;
            Error       <= error_d;
            FrameCount  <= frame_count_d;
        end
    end

endmodule
